// File: rtl/fir_mac_sequencer.sv
// Time-shared FIR filter: one multiplier and one accumulator step through N taps
// per accepted sample, with a double-buffered (shadow/active) coefficient bank.
module fir_mac_sequencer #(
  parameter int unsigned N     = 32,
  parameter int unsigned WIDTH = 14,
  parameter int unsigned CW    = 16
) (
  input  logic                      clk,
  input  logic                      n_rst,
  input  logic                      i_din_valid,
  input  logic signed [WIDTH-1:0]   i_din,
  input  logic                      i_coef_we,
  input  logic [$clog2(N)-1:0]      i_coef_addr,
  input  logic signed [CW-1:0]      i_coef_wdata,
  input  logic                      i_coef_swap,
  input  logic                      i_overrun_clr,
  output logic                      o_dout_valid,
  output logic signed [WIDTH+15:0]  o_dout,
  output logic                      o_busy,
  output logic                      o_overrun
);

  localparam int unsigned AW    = $clog2(N);
  localparam int unsigned PW    = WIDTH + CW;
  localparam int unsigned ACC_W = WIDTH + CW + AW;
  localparam int unsigned OW    = WIDTH + 16;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_DRAIN = 2'd2,
    S_OUT   = 2'd3
  } state_t;

  state_t                   r_state;
  logic [AW-1:0]            r_tap;
  logic                     r_drain;
  logic [AW-1:0]            r_wp;
  logic                     r_swap_pend;
  logic signed [WIDTH-1:0]  r_hist   [N];
  logic signed [CW-1:0]     r_shadow [N];
  logic signed [CW-1:0]     r_active [N];
  logic signed [WIDTH-1:0]  r_x;
  logic signed [CW-1:0]     r_c;
  logic                     r_rd_vld;
  logic signed [PW-1:0]     r_prod;
  logic                     r_p_vld;
  logic signed [ACC_W-1:0]  r_acc;
  logic                     r_dout_valid;
  logic signed [OW-1:0]     r_dout;
  logic                     r_busy;
  logic                     r_overrun;

  logic                     w_idle;
  logic                     w_accept;
  logic                     w_swap_go;
  logic                     w_ovr_set;
  logic [AW-1:0]            w_rd_idx;
  logic signed [PW-1:0]     w_prod;
  logic [ACC_W-OW:0]        w_acc_hi;
  logic signed [OW-1:0]     w_sat;

  // Control decodes shared by the sequential blocks
  assign w_idle    = (r_state == S_IDLE);
  assign w_accept  = w_idle & i_din_valid;
  assign w_swap_go = w_idle & (r_swap_pend | i_coef_swap);
  assign w_ovr_set = i_din_valid & ~w_idle;
  // Tap k reads the sample written k accepts ago; r_wp already points past the newest
  assign w_rd_idx  = r_wp - AW'(1) - r_tap;
  assign w_prod    = r_x * r_c;

  // Clamp the accumulator into the output range: in range when all bits above the
  // output sign bit agree with it
  assign w_acc_hi  = r_acc[ACC_W-1:OW-1];
  always_comb begin
    w_sat = r_acc[OW-1:0];
    if (!((w_acc_hi == '0) || (w_acc_hi == '1))) begin
      w_sat = r_acc[ACC_W-1] ? {1'b1, {(OW-1){1'b0}}} : {1'b0, {(OW-1){1'b1}}};
    end
  end

  // Sequencer: IDLE -> RUN (N taps) -> DRAIN (2) -> OUT (1) -> IDLE, registered outputs
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      r_state      <= S_IDLE;
      r_tap        <= '0;
      r_drain      <= 1'b0;
      r_busy       <= 1'b0;
      r_dout       <= '0;
      r_dout_valid <= 1'b0;
    end else begin
      r_dout_valid <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (i_din_valid) begin
            r_state <= S_RUN;
            r_tap   <= '0;
            r_busy  <= 1'b1;
          end
        end
        S_RUN: begin
          if (r_tap == AW'(N - 1)) begin
            r_state <= S_DRAIN;
            r_drain <= 1'b0;
          end else begin
            r_tap <= r_tap + AW'(1);
          end
        end
        S_DRAIN: begin
          if (r_drain) begin
            r_state <= S_OUT;
          end else begin
            r_drain <= 1'b1;
          end
        end
        S_OUT: begin
          r_state      <= S_IDLE;
          r_busy       <= 1'b0;
          r_dout       <= w_sat;
          r_dout_valid <= 1'b1;
        end
        default: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  // Sample history ring: written only on an accepted sample
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      r_wp <= '0;
      for (int i = 0; i < N; i++) begin
        r_hist[i] <= '0;
      end
    end else if (w_accept) begin
      r_hist[r_wp] <= i_din;
      r_wp         <= r_wp + AW'(1);
    end
  end

  // Coefficient banks: shadow writable any time, copied to active only while idle
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      r_swap_pend <= 1'b0;
      for (int i = 0; i < N; i++) begin
        r_shadow[i] <= '0;
        r_active[i] <= '0;
      end
    end else begin
      if (w_swap_go) begin
        r_swap_pend <= 1'b0;
        for (int i = 0; i < N; i++) begin
          r_active[i] <= r_shadow[i];
        end
      end else if (i_coef_swap) begin
        r_swap_pend <= 1'b1;
      end
      // Non-blocking update, so a same-edge copy still sees the old shadow word
      if (i_coef_we) begin
        r_shadow[i_coef_addr] <= i_coef_wdata;
      end
    end
  end

  // MAC pipeline: operand read, full-precision multiply, sign-extended accumulate
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      r_x      <= '0;
      r_c      <= '0;
      r_rd_vld <= 1'b0;
      r_prod   <= '0;
      r_p_vld  <= 1'b0;
      r_acc    <= '0;
    end else begin
      r_rd_vld <= (r_state == S_RUN);
      if (r_state == S_RUN) begin
        r_x <= r_hist[w_rd_idx];
        r_c <= r_active[r_tap];
      end
      r_p_vld <= r_rd_vld;
      r_prod  <= w_prod;
      if (w_accept) begin
        r_acc <= '0;
      end else if (r_p_vld) begin
        r_acc <= r_acc + ACC_W'(r_prod);
      end
    end
  end

  // Sticky overrun: a sample arriving while busy is dropped; set wins over clear
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      r_overrun <= 1'b0;
    end else if (w_ovr_set) begin
      r_overrun <= 1'b1;
    end else if (i_overrun_clr) begin
      r_overrun <= 1'b0;
    end
  end

  assign o_dout_valid = r_dout_valid;
  assign o_dout       = r_dout;
  assign o_busy       = r_busy;
  assign o_overrun    = r_overrun;

endmodule

// File: tb/tb_fir_mac_sequencer.sv
// Bench for fir_mac_sequencer: transaction-level reference model plus directed
// and randomized stimulus.
module tb_fir_mac_sequencer;

  localparam int N     = 32;
  localparam int WIDTH = 14;
  localparam int CW    = 16;
  localparam int AW    = 5;
  localparam int OW    = WIDTH + 16;
  localparam longint SMAX = (longint'(1) <<< (OW - 1)) - 1;
  localparam longint SMIN = -(longint'(1) <<< (OW - 1));

  logic                     clk = 1'b0;
  logic                     n_rst;
  logic                     din_valid;
  logic signed [WIDTH-1:0]  din;
  logic                     coef_we;
  logic [AW-1:0]            coef_addr;
  logic signed [CW-1:0]     coef_wdata;
  logic                     coef_swap;
  logic                     overrun_clr;
  logic                     dout_valid;
  logic signed [OW-1:0]     dout;
  logic                     busy;
  logic                     overrun;

  fir_mac_sequencer #(.N(N), .WIDTH(WIDTH), .CW(CW)) dut (
    .clk          (clk),
    .n_rst        (n_rst),
    .i_din_valid  (din_valid),
    .i_din        (din),
    .i_coef_we    (coef_we),
    .i_coef_addr  (coef_addr),
    .i_coef_wdata (coef_wdata),
    .i_coef_swap  (coef_swap),
    .i_overrun_clr(overrun_clr),
    .o_dout_valid (dout_valid),
    .o_dout       (dout),
    .o_busy       (busy),
    .o_overrun    (overrun)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;
  int dv_count = 0;
  int cycles = 0;
  int last_lat = 0;

  // Reference model: result computed whole at accept time, released N+3 edges later
  int     m_hist   [N];
  int     m_shadow [N];
  int     m_active [N];
  int     m_wp;
  int     m_left;
  bit     m_pend;
  bit     m_dv;
  bit     m_ovr;
  longint m_dout;
  longint m_res;

  function automatic longint sat(input longint v);
    if (v > SMAX) return SMAX;
    if (v < SMIN) return SMIN;
    return v;
  endfunction

  always @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      for (int k = 0; k < N; k++) begin
        m_hist[k] = 0; m_shadow[k] = 0; m_active[k] = 0;
      end
      m_wp = 0; m_left = 0; m_pend = 0; m_dv = 0; m_ovr = 0; m_dout = 0; m_res = 0;
    end else begin
      bit     busy_now;
      longint acc;
      busy_now = (m_left != 0);
      m_dv = 0;
      if (busy_now) begin
        m_left = m_left - 1;
        if (m_left == 0) begin
          m_dout = m_res;
          m_dv   = 1;
        end
      end
      if (din_valid && busy_now) m_ovr = 1;
      else if (overrun_clr) m_ovr = 0;
      if (!busy_now && (m_pend || coef_swap)) begin
        for (int k = 0; k < N; k++) m_active[k] = m_shadow[k];
        m_pend = 0;
      end else if (coef_swap) begin
        m_pend = 1;
      end
      if (coef_we) m_shadow[int'(coef_addr)] = int'(coef_wdata);
      if (!busy_now && din_valid) begin
        m_hist[m_wp] = int'(din);
        acc = 0;
        for (int k = 0; k < N; k++)
          acc += longint'(m_hist[(m_wp - k + N) % N]) * longint'(m_active[k]);
        m_res  = sat(acc);
        m_wp   = (m_wp + 1) % N;
        m_left = N + 3;
      end
    end
  end

  // Advance one cycle and compare every DUT output against the model
  task automatic tick();
    @(negedge clk);
    cycles++;
    if (n_rst) begin
      n_tests++;
      if (dout_valid !== m_dv || busy !== (m_left != 0) || overrun !== m_ovr ||
          longint'(dout) !== m_dout) begin
        n_fail++;
        $display("FAIL model cycle %0d: dv=%0b/%0b busy=%0b/%0b ovr=%0b/%0b dout=%0d/%0d",
                 cycles, dout_valid, m_dv, busy, (m_left != 0), overrun, m_ovr,
                 dout, m_dout);
      end
      if (dout_valid) dv_count++;
    end
  endtask

  task automatic check(input string name, input longint got, input longint exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, got, exp);
    end
  endtask

  task automatic write_bank(input int mode, input int val);
    for (int k = 0; k < N; k++) begin
      coef_we    = 1'b1;
      coef_addr  = AW'(k);
      coef_wdata = (mode == 1) ? CW'(k + 1) : CW'(val);
      tick();
    end
    coef_we = 1'b0;
  endtask

  task automatic swap();
    coef_swap = 1'b1;
    tick();
    coef_swap = 1'b0;
  endtask

  // Send one sample; optionally a duplicate strobe or a swap at a given cycle offset
  task automatic send(input int d, input int dup_at, input int swap_at, output longint res);
    bit found;
    found = 0;
    res = 0;
    last_lat = 0;
    din_valid = 1'b1;
    din = WIDTH'(d);
    tick();
    din_valid = 1'b0;
    for (int i = 0; i < 60; i++) begin
      tick();
      last_lat++;
      din_valid = (last_lat == dup_at);
      din       = WIDTH'(77);
      coef_swap = (last_lat == swap_at);
      if (dout_valid) begin
        res = longint'(dout);
        found = 1;
        break;
      end
    end
    din_valid = 1'b0;
    coef_swap = 1'b0;
    if (!found) begin
      n_tests++;
      n_fail++;
      $display("FAIL timeout: no dout_valid within 60 cycles, expected one");
    end
    repeat (4) tick();
  endtask

  initial begin
    longint r;
    int     dv0;
    n_rst = 1'b0; din_valid = 1'b0; din = '0; coef_we = 1'b0; coef_addr = '0;
    coef_wdata = '0; coef_swap = 1'b0; overrun_clr = 1'b0;
    repeat (3) tick();
    check("reset_dout", longint'(dout), 0);
    check("reset_flags", {dout_valid, busy, overrun}, 0);
    n_rst = 1'b1;
    repeat (2) tick();

    // Impulse response through a ramp bank
    write_bank(1, 0);
    swap();
    send(1, -1, -1, r);
    check("impulse_0", r, 1);
    check("impulse_latency", last_lat, 35);
    for (int i = 0; i < 32; i++) begin
      send(0, -1, -1, r);
      check($sformatf("impulse_%0d", i + 1), r, (i < 31) ? i + 2 : 0);
    end

    // DC gain
    write_bank(0, 100);
    swap();
    for (int i = 0; i < 32; i++) send(8191, -1, -1, r);
    check("dc_32", r, 26211200);

    // Negative saturation
    write_bank(0, 32767);
    swap();
    for (int i = 0; i < 32; i++) send(-8192, -1, -1, r);
    check("sat_final", r, -536870912);

    // Overrun: second strobe 5 cycles after accept is dropped
    write_bank(0, 1);
    swap();
    dv0 = dv_count;
    send(5, 4, -1, r);
    check("ovr_result", r, 5 - 31 * 8192);
    check("ovr_single_pulse", dv_count - dv0, 1);
    check("ovr_flag_set", overrun, 1);
    send(0, -1, -1, r);
    check("ovr_history", r, 5 - 30 * 8192);
    overrun_clr = 1'b1;
    tick();
    overrun_clr = 1'b0;
    tick();
    check("ovr_cleared", overrun, 0);

    // Reset mid-RUN aborts the computation
    din_valid = 1'b1; din = WIDTH'(1);
    tick();
    din_valid = 1'b0;
    repeat (4) tick();
    din_valid = 1'b1;
    tick();
    din_valid = 1'b0;
    repeat (4) tick();
    check("pre_reset_busy", busy, 1);
    check("pre_reset_ovr", overrun, 1);
    dv0 = dv_count;
    n_rst = 1'b0;
    #1;
    check("rst_dout", longint'(dout), 0);
    check("rst_flags", {dout_valid, busy, overrun}, 0);
    repeat (2) tick();
    n_rst = 1'b1;
    repeat (40) tick();
    check("rst_no_pulse", dv_count - dv0, 0);
    send(1, -1, -1, r);
    check("rst_impulse_zero", r, 0);

    // Deferred swap: bank A=1 active, bank B=2 swapped mid-RUN
    write_bank(0, 1);
    swap();
    write_bank(0, 2);
    send(3, -1, 5, r);
    check("swap_old_bank", r, 4);
    send(0, -1, -1, r);
    check("swap_new_bank", r, 8);

    // Randomized traffic including overlapping strobes and swaps
    for (int i = 0; i < 4000; i++) begin
      din_valid   = ($urandom_range(0, 17) == 0);
      din         = WIDTH'($urandom);
      coef_we     = ($urandom_range(0, 3) == 0);
      coef_addr   = AW'($urandom);
      coef_wdata  = CW'($urandom);
      coef_swap   = ($urandom_range(0, 59) == 0);
      overrun_clr = ($urandom_range(0, 24) == 0);
      tick();
    end
    din_valid = 1'b0; coef_we = 1'b0; coef_swap = 1'b0; overrun_clr = 1'b0;
    repeat (40) tick();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
